// File: rtl/zvc_pkg.sv
// Shared definitions for the zero-value compaction stream block: default widths,
// drop-mode encodings and an elaboration-time clog2 helper.
package zvc_pkg;

  localparam int LINE_LEN_DEF      = 128;
  localparam int WORD_WIDTH_DEF    = 8;
  localparam int DIST_WIDTH_DEF    = 7;
  localparam int MAX_LIFM_RSIZ_DEF = 4;

  typedef enum logic [1:0] {
    MODE_MT_ZERO     = 2'd0,
    MODE_LIFM_ZERO   = 2'd1,
    MODE_EITHER_ZERO = 2'd2,
    MODE_BYPASS      = 2'd3
  } zvc_mode_e;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/zvc_prefix_sum.sv
// Exclusive prefix sum of a per-word drop mask: entry i counts the dropped words
// below index i, which is exactly how far a kept word i must slide toward slot 0.
module zvc_prefix_sum
  import zvc_pkg::*;
#(
  parameter int  LINE_LEN  = LINE_LEN_DEF,
  localparam int IDX_WIDTH = clog2(LINE_LEN),
  localparam int CNT_WIDTH = IDX_WIDTH + 1
) (
  input  logic [LINE_LEN-1:0]           i_mask,
  output logic [LINE_LEN*IDX_WIDTH-1:0] o_prefix,
  output logic [CNT_WIDTH-1:0]          o_total
);

  // Running count; an index-i entry never exceeds i, so IDX_WIDTH bits suffice.
  always_comb begin : p_scan
    logic [CNT_WIDTH-1:0] w_acc;
    w_acc    = '0;
    o_prefix = '0;
    for (int i = 0; i < LINE_LEN; i++) begin
      o_prefix[i*IDX_WIDTH +: IDX_WIDTH] = w_acc[IDX_WIDTH-1:0];
      w_acc = w_acc + CNT_WIDTH'(i_mask[i]);
    end
    o_total = w_acc;
  end

endmodule

// File: rtl/zvc_stream_compressor.sv
// Zero-value compaction stage: drops words by a per-line mode criterion and packs the
// survivors (with their mapping entries) toward slot 0 through a 2-stage valid/ready pipe.
module zvc_stream_compressor
  import zvc_pkg::*;
#(
  parameter int  LINE_LEN      = LINE_LEN_DEF,
  parameter int  WORD_WIDTH    = WORD_WIDTH_DEF,
  parameter int  DIST_WIDTH    = DIST_WIDTH_DEF,
  parameter int  MAX_LIFM_RSIZ = MAX_LIFM_RSIZ_DEF,
  localparam int CNT_WIDTH     = clog2(LINE_LEN) + 1,
  localparam int ENT_WIDTH     = DIST_WIDTH * MAX_LIFM_RSIZ
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [LINE_LEN*WORD_WIDTH-1:0] lifm_line,
  input  logic [LINE_LEN*ENT_WIDTH-1:0]  mt_line,
  input  logic [1:0]                     mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [LINE_LEN*WORD_WIDTH-1:0] lifm_comp,
  output logic [LINE_LEN*ENT_WIDTH-1:0]  mt_comp,
  output logic [CNT_WIDTH-1:0]           nz_count,
  output logic                           out_last,
  output logic [31:0]                    frame_count
);

  localparam int SHW = clog2(LINE_LEN);

  logic [LINE_LEN-1:0]            w_drop;
  logic [LINE_LEN*SHW-1:0]        w_prefix;
  logic [CNT_WIDTH-1:0]           w_drop_total;
  logic [CNT_WIDTH-1:0]           w_keep_cnt;
  logic                           w_in_fire;
  logic                           w_s2_load;
  logic                           w_out_fire;
  logic [LINE_LEN*WORD_WIDTH-1:0] w_comp_lifm;
  logic [LINE_LEN*ENT_WIDTH-1:0]  w_comp_mt;

  logic                           r_s1_valid;
  logic [LINE_LEN*WORD_WIDTH-1:0] r_s1_lifm;
  logic [LINE_LEN*ENT_WIDTH-1:0]  r_s1_mt;
  logic [LINE_LEN-1:0]            r_s1_keep;
  logic [LINE_LEN*SHW-1:0]        r_s1_prefix;
  logic [CNT_WIDTH-1:0]           r_s1_cnt;
  logic                           r_s1_last;

  logic                           r_s2_valid;
  logic [LINE_LEN*WORD_WIDTH-1:0] r_lifm_comp;
  logic [LINE_LEN*ENT_WIDTH-1:0]  r_mt_comp;
  logic [CNT_WIDTH-1:0]           r_nz_count;
  logic                           r_s2_last;
  logic [31:0]                    r_frame_count;
  logic                           r_frame_done;

  // Per-word drop decision for the line currently offered upstream.
  always_comb begin
    w_drop = '0;
    for (int i = 0; i < LINE_LEN; i++) begin
      case (zvc_mode_e'(mode))
        MODE_MT_ZERO:     w_drop[i] = (mt_line[i*ENT_WIDTH +: ENT_WIDTH] == '0);
        MODE_LIFM_ZERO:   w_drop[i] = (lifm_line[i*WORD_WIDTH +: WORD_WIDTH] == '0);
        MODE_EITHER_ZERO: w_drop[i] = (mt_line[i*ENT_WIDTH +: ENT_WIDTH] == '0) |
                                      (lifm_line[i*WORD_WIDTH +: WORD_WIDTH] == '0);
        MODE_BYPASS:      w_drop[i] = 1'b0;
        default:          w_drop[i] = 1'b0;
      endcase
    end
  end

  zvc_prefix_sum #(
    .LINE_LEN (LINE_LEN)
  ) u_prefix_sum (
    .i_mask   (w_drop),
    .o_prefix (w_prefix),
    .o_total  (w_drop_total)
  );

  assign w_keep_cnt = CNT_WIDTH'(LINE_LEN) - w_drop_total;

  // S1 may take a new line while its current one moves into S2 in the same cycle.
  assign w_s2_load  = r_s1_valid & (~r_s2_valid | out_ready);
  assign in_ready   = reset_n & (~r_s1_valid | w_s2_load);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_s2_valid & out_ready;

  // Stage 1: capture the line, its keep mask, slide distances and keep count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_lifm   <= '0;
      r_s1_mt     <= '0;
      r_s1_keep   <= '0;
      r_s1_prefix <= '0;
      r_s1_cnt    <= '0;
      r_s1_last   <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_valid  <= 1'b1;
      r_s1_lifm   <= lifm_line;
      r_s1_mt     <= mt_line;
      r_s1_keep   <= ~w_drop;
      r_s1_prefix <= w_prefix;
      r_s1_cnt    <= w_keep_cnt;
      r_s1_last   <= in_last;
    end else if (w_s2_load) begin
      r_s1_valid  <= 1'b0;
    end
  end

  // Bubble-collapse: level l slides a kept word by 2**l when bit l of its distance is
  // set. Applying bits LSB-first keeps order and never lands two words on one slot.
  always_comb begin : p_compact
    logic [WORD_WIDTH-1:0] w_lv_lifm [SHW+1][LINE_LEN];
    logic [ENT_WIDTH-1:0]  w_lv_mt   [SHW+1][LINE_LEN];
    logic [SHW-1:0]        w_lv_sh   [SHW+1][LINE_LEN];
    logic                  w_lv_keep [SHW+1][LINE_LEN];
    int                    w_hi;
    logic                  w_take_hi;
    logic                  w_stay;
    w_hi        = 0;
    w_take_hi   = 1'b0;
    w_stay      = 1'b0;
    w_comp_lifm = '0;
    w_comp_mt   = '0;
    for (int l = 0; l <= SHW; l++) begin
      for (int p = 0; p < LINE_LEN; p++) begin
        w_lv_lifm[l][p] = '0;
        w_lv_mt[l][p]   = '0;
        w_lv_sh[l][p]   = '0;
        w_lv_keep[l][p] = 1'b0;
      end
    end
    for (int p = 0; p < LINE_LEN; p++) begin
      w_lv_lifm[0][p] = r_s1_lifm[p*WORD_WIDTH +: WORD_WIDTH];
      w_lv_mt[0][p]   = r_s1_mt[p*ENT_WIDTH +: ENT_WIDTH];
      w_lv_sh[0][p]   = r_s1_prefix[p*SHW +: SHW];
      w_lv_keep[0][p] = r_s1_keep[p];
    end
    for (int l = 0; l < SHW; l++) begin
      for (int p = 0; p < LINE_LEN; p++) begin
        w_hi      = ((p + (1 << l)) < LINE_LEN) ? (p + (1 << l)) : p;
        w_take_hi = (w_hi != p) && w_lv_keep[l][w_hi] && w_lv_sh[l][w_hi][l];
        w_stay    = w_lv_keep[l][p] && !w_lv_sh[l][p][l];
        if (w_take_hi) begin
          w_lv_lifm[l+1][p] = w_lv_lifm[l][w_hi];
          w_lv_mt[l+1][p]   = w_lv_mt[l][w_hi];
          w_lv_sh[l+1][p]   = w_lv_sh[l][w_hi];
          w_lv_keep[l+1][p] = 1'b1;
        end else if (w_stay) begin
          w_lv_lifm[l+1][p] = w_lv_lifm[l][p];
          w_lv_mt[l+1][p]   = w_lv_mt[l][p];
          w_lv_sh[l+1][p]   = w_lv_sh[l][p];
          w_lv_keep[l+1][p] = 1'b1;
        end else begin
          w_lv_lifm[l+1][p] = '0;
          w_lv_mt[l+1][p]   = '0;
          w_lv_sh[l+1][p]   = '0;
          w_lv_keep[l+1][p] = 1'b0;
        end
      end
    end
    for (int p = 0; p < LINE_LEN; p++) begin
      w_comp_lifm[p*WORD_WIDTH +: WORD_WIDTH] = w_lv_lifm[SHW][p];
      w_comp_mt[p*ENT_WIDTH +: ENT_WIDTH]     = w_lv_mt[SHW][p];
    end
  end

  // Stage 2: registered compacted line, held while downstream stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s2_valid  <= 1'b0;
      r_lifm_comp <= '0;
      r_mt_comp   <= '0;
      r_nz_count  <= '0;
      r_s2_last   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid  <= 1'b1;
      r_lifm_comp <= w_comp_lifm;
      r_mt_comp   <= w_comp_mt;
      r_nz_count  <= r_s1_cnt;
      r_s2_last   <= r_s1_last;
    end else if (out_ready) begin
      r_s2_valid  <= 1'b0;
    end
  end

  // Kept-word total of the frame leaving the block; restarts after an out_last handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_count <= 32'd0;
      r_frame_done  <= 1'b0;
    end else if (w_out_fire) begin
      if (r_frame_done) begin
        r_frame_count <= 32'(r_nz_count);
      end else begin
        r_frame_count <= r_frame_count + 32'(r_nz_count);
      end
      r_frame_done <= r_s2_last;
    end
  end

  assign out_valid   = r_s2_valid;
  assign lifm_comp   = r_lifm_comp;
  assign mt_comp     = r_mt_comp;
  assign nz_count    = r_nz_count;
  assign out_last    = r_s2_last;
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_zvc_stream_compressor.sv
// Directed + randomized bench for zvc_stream_compressor (LINE_LEN=8, 8-bit words,
// one 7-bit distance per entry) against a queue-based reference model.
module tb_zvc_stream_compressor;

  localparam int LL = 8;
  localparam int WW = 8;
  localparam int DW = 7;
  localparam int MR = 1;
  localparam int EW = DW * MR;
  localparam int CW = 4;

  logic            clk;
  logic            reset_n;
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [LL*WW-1:0] lifm_line;
  logic [LL*EW-1:0] mt_line;
  logic [1:0]      mode;
  logic            out_valid;
  logic            out_ready;
  logic [LL*WW-1:0] lifm_comp;
  logic [LL*EW-1:0] mt_comp;
  logic [CW-1:0]   nz_count;
  logic            out_last;
  logic [31:0]     frame_count;

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  bit last_in_fire = 1'b0;

  logic [LL*WW-1:0] q_lifm[$];
  logic [LL*EW-1:0] q_mt[$];
  int               q_nz[$];
  bit               q_last[$];
  int               exp_frame = 0;
  bit               frame_done = 1'b0;

  zvc_stream_compressor #(
    .LINE_LEN      (LL),
    .WORD_WIDTH    (WW),
    .DIST_WIDTH    (DW),
    .MAX_LIFM_RSIZ (MR)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_last     (in_last),
    .lifm_line   (lifm_line),
    .mt_line     (mt_line),
    .mode        (mode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .lifm_comp   (lifm_comp),
    .mt_comp     (mt_comp),
    .nz_count    (nz_count),
    .out_last    (out_last),
    .frame_count (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: kept words in ascending index order fill slots 0,1,2,...; rest zero.
  task automatic model_push(input logic [LL*WW-1:0] l, input logic [LL*EW-1:0] m,
                            input logic [1:0] md, input logic lst);
    logic [LL*WW-1:0] el;
    logic [LL*EW-1:0] em;
    logic [WW-1:0]    w;
    logic [EW-1:0]    e;
    bit               drop;
    int               k;
    el = '0;
    em = '0;
    k  = 0;
    for (int i = 0; i < LL; i++) begin
      w = l[i*WW +: WW];
      e = m[i*EW +: EW];
      drop = (md == 2'd0 && e == 0) || (md == 2'd1 && w == 0) ||
             (md == 2'd2 && (e == 0 || w == 0));
      if (!drop) begin
        el[k*WW +: WW] = w;
        em[k*EW +: EW] = e;
        k++;
      end
    end
    q_lifm.push_back(el);
    q_mt.push_back(em);
    q_nz.push_back(k);
    q_last.push_back(lst);
  endtask

  // One clock: score any output handshake, record any input handshake, then advance.
  task automatic tick();
    bit in_fire;
    bit out_fire;
    #1;
    in_fire  = (in_valid === 1'b1) && (in_ready === 1'b1);
    out_fire = (out_valid === 1'b1) && (out_ready === 1'b1);
    if (out_fire) begin
      chk("out_expected", 64'(q_nz.size() > 0), 64'd1);
      if (q_nz.size() > 0) begin
        chk("lifm_comp", 64'(lifm_comp), 64'(q_lifm[0]));
        chk("mt_comp", 64'(mt_comp), 64'(q_mt[0]));
        chk("nz_count", 64'(nz_count), 64'(q_nz[0]));
        chk("out_last", 64'(out_last), 64'(q_last[0]));
        exp_frame  = frame_done ? q_nz[0] : exp_frame + q_nz[0];
        frame_done = q_last[0];
        void'(q_lifm.pop_front());
        void'(q_mt.pop_front());
        void'(q_nz.pop_front());
        void'(q_last.pop_front());
      end
    end
    if (in_fire) model_push(lifm_line, mt_line, mode, in_last);
    @(posedge clk);
    #1;
    if (out_fire) begin
      chk("frame_count", 64'(frame_count), 64'(exp_frame));
      n_out++;
    end
    last_in_fire = in_fire;
  endtask

  function automatic logic [LL*WW-1:0] rand_lifm(input int dens);
    logic [LL*WW-1:0] v;
    v = '0;
    for (int i = 0; i < LL; i++)
      if ($urandom_range(0, 99) < dens) v[i*WW +: WW] = WW'($urandom_range(1, 255));
    return v;
  endfunction

  function automatic logic [LL*EW-1:0] rand_mt(input int dens);
    logic [LL*EW-1:0] v;
    v = '0;
    for (int i = 0; i < LL; i++)
      if ($urandom_range(0, 99) < dens) v[i*EW +: EW] = EW'($urandom_range(1, 127));
    return v;
  endfunction

  // Offer one line alone and confirm it shows up exactly two cycles after acceptance.
  task automatic send_one(input logic [LL*WW-1:0] l, input logic [LL*EW-1:0] m,
                          input logic [1:0] md, input logic lst, input string tag);
    lifm_line = l;
    mt_line   = m;
    mode      = md;
    in_last   = lst;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    chk({tag, "_accept"}, 64'(last_in_fire), 64'd1);
    in_valid = 1'b0;
    chk({tag, "_valid_c1"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, "_valid_c2"}, 64'(out_valid), 64'd1);
  endtask

  logic [LL*WW-1:0] l3[3];
  logic [LL*EW-1:0] m3[3];
  logic [1:0]       md3[3];
  logic [LL*WW-1:0] lz;
  int               idx;

  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    lifm_line = '0;
    mt_line   = '0;
    mode      = 2'd0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_frame_count", 64'(frame_count), 64'd0);
    chk("rst_nz_count", 64'(nz_count), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);

    // mode 1: {0,5,0,7,0,0,9,0} -> {5,7,9,0,...}, nz 3 (first line of a frame)
    send_one(64'h0009_0000_0700_0500, rand_mt(100), 2'd1, 1'b0, "m1");
    chk("m1_lifm_const", 64'(lifm_comp), 64'h0000_0000_0009_0705);
    chk("m1_nz_const", 64'(nz_count), 64'd3);
    tick();
    chk("frame_after_3", 64'(frame_count), 64'd3);

    // mode 0 with all-zero mt: everything dropped, still valid
    lz = rand_lifm(80);
    send_one(lz, '0, 2'd0, 1'b0, "m0z");
    chk("m0z_nz", 64'(nz_count), 64'd0);
    chk("m0z_lifm", 64'(lifm_comp), 64'd0);
    chk("m0z_mt", 64'(mt_comp), 64'd0);
    tick();
    chk("frame_after_0", 64'(frame_count), 64'd3);

    // mode 3 on the same line: passthrough, closes the frame at 3+0+8
    send_one(lz, '0, 2'd3, 1'b1, "m3");
    chk("m3_lifm", 64'(lifm_comp), 64'(lz));
    chk("m3_mt", 64'(mt_comp), 64'd0);
    chk("m3_nz", 64'(nz_count), 64'd8);
    chk("m3_last", 64'(out_last), 64'd1);
    tick();
    chk("frame_total_11", 64'(frame_count), 64'd11);

    // First line of the next frame (nz 2) restarts the count
    send_one(64'h0022_0000_0011_0000, rand_mt(100), 2'd1, 1'b0, "nf");
    chk("nf_lifm", 64'(lifm_comp), 64'h0000_0000_0000_2211);
    chk("nf_nz", 64'(nz_count), 64'd2);
    tick();
    chk("frame_restart_2", 64'(frame_count), 64'd2);

    // 10 back-to-back lines at full throughput
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 10);
      if (c < 10) begin
        lifm_line = rand_lifm(50);
        mt_line   = rand_mt(70);
        mode      = 2'($urandom_range(0, 3));
        in_last   = 1'b0;
      end
      if (c >= 2) chk("b2b_out_valid", 64'(out_valid), 64'd1);
      tick();
      if (c < 10) chk("b2b_in_accept", 64'(last_in_fire), 64'd1);
    end
    in_valid = 1'b0;
    chk("b2b_drained", 64'(q_nz.size()), 64'd0);

    // Downstream stall while offering 3 lines
    for (int j = 0; j < 3; j++) begin
      l3[j]  = rand_lifm(50);
      m3[j]  = rand_mt(60);
      md3[j] = 2'($urandom_range(0, 2));
    end
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (idx < 3);
      if (idx < 3) begin
        lifm_line = l3[idx];
        mt_line   = m3[idx];
        mode      = md3[idx];
      end
      if (c >= 2) begin
        chk("stall_in_ready", 64'(in_ready), 64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        chk("stall_hold_lifm", 64'(lifm_comp), 64'(q_lifm[0]));
        chk("stall_hold_nz", 64'(nz_count), 64'(q_nz[0]));
      end
      tick();
      if (last_in_fire) idx++;
    end
    chk("stall_accepted", 64'(idx), 64'd2);
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      in_valid = (idx < 3);
      if (idx < 3) begin
        lifm_line = l3[idx];
        mt_line   = m3[idx];
        mode      = md3[idx];
      end
      if (idx == 3 && q_nz.size() == 0) break;
      tick();
      if (last_in_fire) idx++;
    end
    in_valid = 1'b0;
    chk("stall_all_in", 64'(idx), 64'd3);
    chk("stall_drained", 64'(q_nz.size()), 64'd0);

    // Randomized valid/ready traffic with random modes and frame ends
    last_in_fire = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || last_in_fire) begin
        lifm_line = rand_lifm(50);
        mt_line   = rand_mt(60);
        mode      = 2'($urandom_range(0, 3));
        in_last   = ($urandom_range(0, 3) == 0);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (q_nz.size() == 0) break;
      tick();
    end
    chk("rand_drained", 64'(q_nz.size()), 64'd0);

    // Reset with two lines in flight
    out_ready = 1'b0;
    in_last   = 1'b0;
    for (int c = 0; c < 2; c++) begin
      lifm_line = rand_lifm(60);
      mt_line   = rand_mt(60);
      mode      = 2'd2;
      in_valid  = 1'b1;
      tick();
      chk("fill_accept", 64'(last_in_fire), 64'd1);
    end
    in_valid = 1'b0;
    chk("fill_out_valid", 64'(out_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_frame", 64'(frame_count), 64'd0);
    chk("mid_rst_nz", 64'(nz_count), 64'd0);
    chk("mid_rst_lifm", 64'(lifm_comp), 64'd0);
    q_lifm.delete();
    q_mt.delete();
    q_nz.delete();
    q_last.delete();
    exp_frame  = 0;
    frame_done = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    lifm_line = rand_lifm(60);
    mt_line   = rand_mt(60);
    mode      = 2'd2;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_accept", 64'(last_in_fire), 64'd1);
    in_valid = 1'b0;
    idx = n_out;
    repeat (4) tick();
    chk("post_rst_one_out", 64'(n_out - idx), 64'd1);
    chk("post_rst_drained", 64'(q_nz.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/zvc_stream_compressor.md
ZVC_STREAM_COMPRESSOR -- requirements
Module: zvc_stream_compressor

Interface
REQ-001 SHALL have parameter LINE_LEN, default 128, words per line (power of two, 8..256).
REQ-002 SHALL have parameter WORD_WIDTH, default 8, bits per LIFM word.
REQ-003 SHALL have parameter DIST_WIDTH, default 7, bits per mapping-table distance.
REQ-004 SHALL have parameter MAX_LIFM_RSIZ, default 4, distances per mapping-table entry.
REQ-005 SHALL have localparam CNT_WIDTH = clog2(LINE_LEN)+1 and ENT_WIDTH = DIST_WIDTH*MAX_LIFM_RSIZ.
REQ-006 SHALL have port clk, input, 1, clock.
REQ-007 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream handshake.
REQ-009 SHALL have port in_last, input, 1, marks the last line of a frame.
REQ-010 SHALL have port lifm_line, input, LINE_LEN*WORD_WIDTH, with word i at bits [i*WORD_WIDTH +: WORD_WIDTH].
REQ-011 SHALL have port mt_line, input, LINE_LEN*ENT_WIDTH, with entry i at bits [i*ENT_WIDTH +: ENT_WIDTH].
REQ-012 SHALL have port mode, input, 2, drop criterion: 0 = mt entry zero, 1 = lifm word zero, 2 = either zero, 3 = bypass.
REQ-013 SHALL have ports out_valid (output, 1) and out_ready (input, 1): downstream handshake.
REQ-014 SHALL have ports lifm_comp (output, LINE_LEN*WORD_WIDTH) and mt_comp (output, LINE_LEN*ENT_WIDTH): compacted line.
REQ-015 SHALL have ports nz_count (output, CNT_WIDTH) and out_last (output, 1): words kept this line; frame end.
REQ-016 SHALL have port frame_count, output, 32, words kept in the current or last frame; valid when out_last is accepted.

Function
REQ-017 SHALL drop word i when the mode criterion is true for that word, and keep it otherwise; mode 3 keeps all words.
REQ-018 SHALL sample mode together with each accepted input line and carry it with that line.
REQ-019 SHALL place the k-th kept word and its mt entry (k from 0, ascending index) in slot k, and SHALL zero slots nz_count..LINE_LEN-1.
REQ-020 SHALL set nz_count = number of kept words, range 0..LINE_LEN inclusive.
REQ-021 SHALL use a 2-stage pipeline: S1 registers the line, entries, prefix-sum of the drop mask, and keep count; S2 registers the compacted outputs.
REQ-022 SHALL present a line on the outputs with out_valid exactly 2 cycles after its acceptance when out_ready is held high.
REQ-023 SHALL advance each stage only when that stage is empty or its contents move forward in the same cycle.
REQ-024 SHALL drive in_ready = !S1_full | (S1 moves to S2 this cycle), so one line per cycle is sustained at full throughput.
REQ-025 SHALL hold out_valid and all output data stable while out_valid=1 and out_ready=0.
REQ-026 SHALL never drop or duplicate a line under any valid/ready pattern.
REQ-027 SHALL add nz_count to frame_count on each output handshake.
REQ-028 SHALL reload frame_count with nz_count on the first handshake after an out_last handshake.
REQ-029 SHALL pass an all-zero line (mode 0–2) with nz_count=0, all outputs zero, and out_valid still asserted.

Reset
REQ-030 SHALL, on reset_n low, asynchronously clear both stages' valid flags, all data registers, nz_count, out_last and frame_count.
REQ-031 SHALL hold in_ready=0 and out_valid=0 during reset.
REQ-032 SHALL discard in-flight lines on reset mid-operation and accept new input on the first clock edge after release.

Structure
REQ-033 SHALL place WORD_WIDTH/DIST_WIDTH/MAX_LIFM_RSIZ defaults, mode encodings and a clog2 function in shared package zvc_pkg.
REQ-034 SHALL use one sub-module, zvc_prefix_sum, a parametric LINE_LEN-wide exclusive prefix sum of the drop mask.
REQ-035 SHALL implement compaction as a log2(LINE_LEN)-level bubble-collapse shifter inside this module, combinational between S1 and S2.

Verification (LINE_LEN=8, WORD_WIDTH=8, MAX_LIFM_RSIZ=1)
REQ-036 SHALL cover: mode 1, lifm {0,5,0,7,0,0,9,0} (index 0 first), out_ready=1 -> 2 cycles later lifm_comp {5,7,9,0,0,0,0,0}, nz_count=3.
REQ-037 SHALL cover: mode 0, mt all zero -> nz_count=0, comp all zero, out_valid=1; mode 3 same line -> output equals input, nz_count=8.
REQ-038 SHALL cover: 10 back-to-back lines, out_ready=1 -> in_ready stays 1, 10 outputs in consecutive cycles in order.
REQ-039 SHALL cover: out_ready=0 for 5 cycles while driving 3 lines -> in_ready=0 after 2 accepted, output held stable; all 3 delivered in order after release.
REQ-040 SHALL cover: frame of 3 lines with nz 3,0,8, in_last on the third -> frame_count=11 with out_last; next frame's first line of nz 2 -> frame_count=2.
REQ-041 SHALL cover: reset_n pulse with 2 lines in flight -> out_valid=0 immediately, frame_count=0, no stale output after release.
